// File: rtl/lfsr_seed_engine_if.sv
// Request/result bundle of the LFSR seed engine: seed/count load bus plus the
// done-qualified seed result and status bits.
interface lfsr_seed_engine_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             done;
  logic             eq;
  logic             z;
  logic [WIDTH-1:0] nseed;

  modport master (
    output start, data_in,
    input  done, eq, z, nseed
  );

  modport slave (
    input  start, data_in,
    output done, eq, z, nseed
  );
endinterface

// File: rtl/lfsr_seed_engine.sv
// Loads a seed and an iteration count from one shared bus, then steps a Galois
// LFSR once per clock for that many iterations and holds the result in DONE.
module lfsr_seed_engine #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] ZERO_SUB = WIDTH'(16'h0001)
) (
  input  logic                clk,
  input  logic                rst,
  lfsr_seed_engine_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOADB = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             w_lda;
  logic             w_ldb;
  logic             w_decb;
  logic             w_done;
  logic             w_eq;
  logic [WIDTH-1:0] w_seed_in;
  logic [WIDTH-1:0] w_a_step;

  assign w_eq      = (r_b == '0);
  // A zero seed would lock the LFSR at zero forever, so it is replaced on load.
  assign w_seed_in = (bus.data_in == '0) ? ZERO_SUB : bus.data_in;
  assign w_a_step  = (r_a >> 1) ^ (r_a[0] ? TAPS : '0);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next = r_state;
    w_lda  = 1'b0;
    w_ldb  = 1'b0;
    w_decb = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_lda = bus.start;
        if (bus.start) w_next = S_LOADB;
      end
      S_LOADB: begin
        w_ldb  = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        if (!w_eq) w_decb = 1'b1;
        else       w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (!bus.start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_next;
      if (w_lda)       r_a <= w_seed_in;
      else if (w_decb) r_a <= w_a_step;
      if (w_ldb)       r_b <= bus.data_in;
      else if (w_decb) r_b <= r_b - WIDTH'(1);
    end
  end

  assign bus.done  = w_done;
  assign bus.eq    = w_eq;
  assign bus.z     = r_a[0];
  assign bus.nseed = r_a;

endmodule

// File: tb/tb_lfsr_seed_engine.sv
// Scoreboard bench for lfsr_seed_engine: the driver queues the hand-computed
// result of each request, and a monitor checks it when done rises.
module tb_lfsr_seed_engine;

  localparam int unsigned WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] nseed;
    logic             z;
    int               done_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  logic done_q;
  exp_t sb_q[$];

  lfsr_seed_engine_if #(.WIDTH(WIDTH)) bus ();

  lfsr_seed_engine #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard pop per rising edge of done.
  initial begin
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1 && done_q !== 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("nseed", 32'(bus.nseed), 32'(e.nseed));
          check("z", 32'(bus.z), 32'(e.z));
          check("eq_at_done", 32'(bus.eq), 32'd1);
          check("done_latency_cyc", 32'(cyc), 32'(e.done_cyc));
        end
      end
      done_q = bus.done;
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  // Issue one request; the seed is sampled at the next edge, count one edge later.
  task automatic run_op(input logic [WIDTH-1:0] seed, input logic [WIDTH-1:0] cnt,
                        input logic [WIDTH-1:0] exp_nseed, input logic hold_start);
    exp_t e;
    logic [WIDTH-1:0] loaded;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = seed;
    e.nseed    = exp_nseed;
    e.z        = exp_nseed[0];
    e.done_cyc = cyc + int'(cnt) + 3;
    sb_q.push_back(e);
    @(negedge clk);
    loaded = (seed == '0) ? 16'h0001 : seed;
    check("seed_loaded", 32'(bus.nseed), 32'(loaded));
    bus.data_in = cnt;
    bus.start   = hold_start;
    @(negedge clk);
    bus.data_in = 16'h5A5A;
    wait_done(int'(cnt) + 8);
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;
    #1;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_nseed", 32'(bus.nseed), 32'd0);
    check("rst_z", 32'(bus.z), 32'd0);
    check("rst_eq", 32'(bus.eq), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single step, then three steps, then zero steps from the same seed.
    run_op(16'hACE1, 16'd1, 16'hE270, 1'b0);
    run_op(16'hACE1, 16'd3, 16'h389C, 1'b0);
    run_op(16'hACE1, 16'd0, 16'hACE1, 1'b0);
    // Zero seed is replaced with 0001 before stepping.
    run_op(16'h0000, 16'd1, 16'hB400, 1'b0);

    // start held through DONE: result must hold and nothing reloads.
    run_op(16'h0002, 16'd1, 16'h0001, 1'b1);
    bus.data_in = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_done", 32'(bus.done), 32'd1);
      check("hold_nseed", 32'(bus.nseed), 32'h0001);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("drop_start_idle", 32'(bus.done), 32'd0);
    run_op(16'hACE1, 16'd0, 16'hACE1, 1'b0);

    // Reset in the middle of a long run discards the partial result.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'hACE1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = 16'hFFFF;
    repeat (10) @(negedge clk);
    check("midrun_busy", 32'(bus.done), 32'd0);
    rst = 1'b1;
    #1;
    check("midrun_rst_done", 32'(bus.done), 32'd0);
    check("midrun_rst_nseed", 32'(bus.nseed), 32'd0);
    check("midrun_rst_eq", 32'(bus.eq), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle_done", 32'(bus.done), 32'd0);
      check("post_rst_idle_nseed", 32'(bus.nseed), 32'd0);
    end
    run_op(16'h0001, 16'd2, 16'h5A00, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lfsr_seed_engine.md
Name: lfsr_seed_engine

Overview:
- Controller FSM plus 16-bit datapath that loads a seed and an iteration count from a shared input bus.
- Advances the seed through a Galois LFSR once per clock for the requested count.
- Presents the resulting new seed and the current serial random bit.
- Used as the pseudo-random seed generator feeding downstream blocks; a single `start` request yields one `done`-qualified `nseed`.

Parameters:
WIDTH, 16, width of data_in, seed register A, count register B and nseed
TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1)
ZERO_SUB, 16'h0001, value substituted when a zero seed is loaded

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
start  input  1  request; level-sampled in IDLE and DONE
data_in  input  WIDTH  seed (first load cycle), then count (second load cycle)
done  output  1  high while FSM in DONE; nseed valid
eq  output  1  status: B == 0
z  output  1  serial random bit = A[0]
nseed  output  WIDTH  current contents of seed register A

Behaviour:
- One clock; rst asynchronous, active-high.
- Reset state: FSM=IDLE, A=0, B=0. Outputs: done=0, nseed=0, z=0, eq=1.
- Internal controls are combinational from state and status: lda, ldb, decb.
- FSM states: IDLE, LOADB, RUN, DONE.
- IDLE:
  - lda = start.
  - If start=1: at the edge, A<=data_in (ZERO_SUB if data_in==0), next=LOADB.
  - Else stay in IDLE, registers hold.
- LOADB: ldb=1. At the edge, B<=data_in, next=RUN. `start` is ignored in this state.
- RUN:
  - If eq=0: decb=1; A<=(A>>1) ^ (A[0] ? TAPS : 0); B<=B-1; stay in RUN.
  - If eq=1: next=DONE, A and B hold.
- DONE:
  - done=1; A and B hold.
  - If start=0: next=IDLE. If start=1: stay in DONE; no automatic restart.
  - A new operation requires start low for at least one edge, then high again.
- Latency: count N gives done high after exactly N+3 rising edges, counted from the edge that samples start=1 in IDLE.
- Count 0 gives done after 3 edges, with nseed equal to the loaded seed.
- Max count 16'hFFFF gives 65538 edges.
- B never underflows: decrement happens only when B != 0.
- A never becomes 0 after a load. Zero-seed substitution guarantees no LFSR lockup.
- nseed and z are valid to the consumer only while done=1. Between edges they show intermediate LFSR states.
- Reset asserted at any point (including mid-RUN) returns immediately to the reset state; the partial result is discarded.
- data_in must be stable around the IDLE→LOADB edge (seed) and the LOADB→RUN edge (count). It is don't-care otherwise.
- eq is registered-derived combinational (B==0). No combinational path from data_in to any output.

Test Plan:
1. rst pulse, then start=1 with data_in=16'hACE1, next cycle data_in=1 → done after 4 edges; nseed=16'hE270, z=0, eq=1.
2. Seed 16'hACE1, count 3 → nseed steps ACE1→E270→7138→389C; done after 6 edges with nseed=16'h389C.
3. Seed 16'hACE1, count 0 → done after 3 edges, nseed=16'hACE1, z=1.
4. Seed 0, count 1 → A loads 0001, then nseed=16'hB400 at done.
5. Hold start=1 through DONE → done stays 1, no reload. Drop start for one edge → IDLE, done=0. Reassert start → new load from data_in.
6. Assert rst mid-RUN (seed 16'hACE1, count 16'hFFFF, after 10 edges) → done=0, nseed=0 immediately without a clock edge. After release, the FSM idles until start.
